// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and command opcodes for the SPI slave front-end
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RX,
        ST_DISPATCH,
        ST_WAIT_TX,
        ST_TX,
        ST_DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic logic cmd_expects_response(input logic [1:0] cmd);
        logic rsp;
        case (cmd)
            CMD_RD_DATA:                          rsp = 1'b1;
            CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: rsp = 1'b0;
            default:                              rsp = 1'b0;
        endcase
        return rsp;
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// rtl/spi_slave_ctrl_if.sv - SPI pin and back-end handshake bundle for spi_slave_ctrl
interface spi_slave_ctrl_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
);
    logic               ss_n;
    logic               MOSI;
    logic               MISO;
    logic               valid_MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport master (
        output ss_n, MOSI, tx_data, tx_valid,
        input  MISO, valid_MISO, rx_data, rx_valid
    );

    modport slave (
        input  ss_n, MOSI, tx_data, tx_valid,
        output MISO, valid_MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - parallel-load, MSB-first response shifter driving MISO/valid_MISO
module spi_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              miso,
    output logic              valid_miso,
    output logic              done
);
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              miso_q, miso_d;
    logic              valid_q, valid_d;

    // The MSB goes out on the load edge itself, so cnt counts the bits still to send.
    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        valid_d = valid_q;
        if (clear) begin
            cnt_d   = '0;
            miso_d  = 1'b0;
            valid_d = 1'b0;
        end else if (load) begin
            sh_d    = {load_data[DATA_W-2:0], 1'b0};
            miso_d  = load_data[DATA_W-1];
            valid_d = 1'b1;
            cnt_d   = CW'(DATA_W - 1);
        end else if (valid_q) begin
            if (cnt_q == '0) begin
                valid_d = 1'b0;
                miso_d  = 1'b0;
            end else begin
                miso_d = sh_q[DATA_W-1];
                sh_d   = {sh_q[DATA_W-2:0], 1'b0};
                cnt_d  = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            valid_q <= valid_d;
        end
    end

    assign miso       = miso_q;
    assign valid_miso = valid_q;
    assign done       = valid_q && (cnt_q == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave: 10-bit command deserialiser with read-response serialiser
// Optional response timeout and sticky err flag: SPI_SLV_TIMEOUT_EN
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_W     = 10,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_slave_ctrl_if.slave         bus,
    output logic                    sready,
    output logic                    busy,
    output logic                    err
);
    localparam int BCW = $clog2(FRAME_W);

    if (FRAME_W < 3 || DATA_W < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("spi_slave_ctrl: unsupported parameter set");
    end

    state_t             state_q, state_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               sready_q, sready_d;
    logic               busy_q, busy_d;

    logic               ser_load;
    logic               ser_clear;
    logic               ser_done;
    logic [DATA_W-1:0]  ser_data;
    logic               timeout;

`ifdef SPI_SLV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;

    assign timeout = (state_q == ST_WAIT_TX) && !bus.tx_valid
                     && (tmr_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        tmr_d = '0;
        if (state_q == ST_WAIT_TX && !bus.tx_valid) begin
            tmr_d = tmr_q + 1'b1;
        end
        err_d = err_q | (timeout & ~bus.ss_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // A timed-out read answers all-ones so the master still sees a full byte.
    assign ser_data = timeout ? {DATA_W{1'b1}} : bus.tx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (!bus.ss_n) state_d = ST_SYNC;
            ST_SYNC:     state_d = bus.ss_n ? ST_IDLE : ST_RX;
            ST_RX: begin
                if (bus.ss_n)               state_d = ST_IDLE;
                else if (bit_cnt_q == '0)   state_d = ST_DISPATCH;
            end
            ST_DISPATCH: state_d = cmd_expects_response(frame_q[FRAME_W-1 -: 2])
                                   ? ST_WAIT_TX : ST_DONE;
            ST_WAIT_TX: begin
                if (bus.ss_n)                       state_d = ST_IDLE;
                else if (bus.tx_valid || timeout)   state_d = ST_TX;
            end
            ST_TX: begin
                if (bus.ss_n)       state_d = ST_IDLE;
                else if (ser_done)  state_d = ST_DONE;
            end
            ST_DONE:     if (bus.ss_n) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ser_load   = 1'b0;
        ser_clear  = 1'b0;
        case (state_q)
            ST_SYNC: bit_cnt_d = BCW'(FRAME_W - 1);
            ST_RX: begin
                frame_d   = {frame_q[FRAME_W-2:0], bus.MOSI};
                bit_cnt_d = bit_cnt_q - 1'b1;
            end
            ST_DISPATCH: begin
                rx_data_d  = frame_q;
                rx_valid_d = 1'b1;
            end
            ST_WAIT_TX: ser_load  = !bus.ss_n && (bus.tx_valid || timeout);
            ST_TX:      ser_clear = bus.ss_n;
            default: ;
        endcase
        sready_d = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sready_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sready_q   <= sready_d;
            busy_q     <= busy_d;
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx_ser (
        .clk        (clk),
        .rst        (rst),
        .clear      (ser_clear),
        .load       (ser_load),
        .load_data  (ser_data),
        .miso       (bus.MISO),
        .valid_miso (bus.valid_MISO),
        .done       (ser_done)
    );

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign sready       = sready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - directed scoreboard bench for spi_slave_ctrl
module tb_spi_slave_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic sready, busy, err;

    spi_slave_ctrl_if #(.FRAME_W(10), .DATA_W(8)) bus ();

    spi_slave_ctrl #(
        .FRAME_W     (10),
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .sready (sready),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int rx_pulses  = 0;
    int vm_cycles  = 0;
    logic [9:0] rx_q[$];
    logic       mb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any frame or response bit the DUT presents.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.rx_valid === 1'b1) begin
            rx_pulses++;
            chk("rx_expected", 32'(rx_q.size() != 0), 32'd1);
            if (rx_q.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(rx_q.pop_front()));
        end
        if (bus.valid_MISO === 1'b1) begin
            vm_cycles++;
            chk("miso_expected", 32'(mb_q.size() != 0), 32'd1);
            if (mb_q.size() != 0) chk("miso_bit", 32'(bus.MISO), 32'(mb_q.pop_front()));
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) mb_q.push_back(b[i]);
    endtask

    task automatic start_frame(input logic [9:0] f, input int nbits);
        bus.ss_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = f[9-i];
            tick();
        end
    endtask

    initial begin
        int pulses0;
        int w;
        rst          = 1'b1;
        bus.ss_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        tick();
        tick();
        chk("rst_miso", 32'(bus.MISO), 32'd0);
        chk("rst_valid_miso", 32'(bus.valid_MISO), 32'd0);
        chk("rst_sready", 32'(sready), 32'd1);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // write address
        rx_q.push_back(10'h0A5);
        start_frame(10'h0A5, 10);
        tick();
        chk("wr_rx_valid_timing", 32'(bus.rx_valid), 32'd1);
        chk("wr_rx_pulses", 32'(rx_pulses), 32'd1);
        tick();
        chk("wr_rx_valid_one_cycle", 32'(bus.rx_valid), 32'd0);
        chk("wr_busy_done", 32'(busy), 32'd1);
        chk("wr_sready_done", 32'(sready), 32'd0);
        chk("wr_miso_low", 32'(bus.MISO), 32'd0);
        bus.ss_n = 1'b1;
        tick();
        chk("wr_sready_back", 32'(sready), 32'd1);
        chk("wr_busy_clear", 32'(busy), 32'd0);
        chk("wr_no_valid_miso", 32'(vm_cycles), 32'd0);
        tick();

        // write data with a stray tx_valid that must be ignored
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        rx_q.push_back(10'h1C3);
        start_frame(10'h1C3, 10);
        tick();
        repeat (3) tick();
        chk("ign_tx_valid", 32'(vm_cycles), 32'd0);
        chk("ign_busy_done", 32'(busy), 32'd1);
        bus.ss_n     = 1'b1;
        bus.tx_valid = 1'b0;
        tick();
        tick();

        // read data, response already waiting
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        rx_q.push_back(10'h300);
        push_byte(8'h3C);
        start_frame(10'h300, 10);
        tick();
        chk("rd_rx_valid", 32'(bus.rx_valid), 32'd1);
        tick();
        chk("rd_first_valid", 32'(bus.valid_MISO), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rd_valid_run", 32'(bus.valid_MISO), 32'd1);
        end
        tick();
        chk("rd_valid_end", 32'(bus.valid_MISO), 32'd0);
        chk("rd_bits_drained", 32'(mb_q.size()), 32'd0);
        chk("rd_vm_cycles", 32'(vm_cycles), 32'd8);
        bus.tx_valid = 1'b0;
        bus.ss_n     = 1'b1;
        tick();
        tick();
        chk("rd_sready_back", 32'(sready), 32'd1);

        // late response
        bus.tx_data = 8'hA7;
        rx_q.push_back(10'h3FF);
        start_frame(10'h3FF, 10);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("late_busy", 32'(busy), 32'd1);
            chk("late_no_valid", 32'(bus.valid_MISO), 32'd0);
        end
        push_byte(8'hA7);
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        chk("late_first_valid", 32'(bus.valid_MISO), 32'd1);
        for (int i = 0; i < 20 && bus.valid_MISO === 1'b1; i++) tick();
        chk("late_valid_end", 32'(bus.valid_MISO), 32'd0);
        chk("late_bits_drained", 32'(mb_q.size()), 32'd0);
        chk("late_vm_cycles", 32'(vm_cycles), 32'd16);
        bus.ss_n = 1'b1;
        tick();
        tick();

        // abort after 4 RX bits, then a clean frame
        pulses0 = rx_pulses;
        start_frame(10'h2AA, 4);
        bus.ss_n = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sready", 32'(sready), 32'd1);
        tick();
        tick();
        chk("abort_no_rx_valid", 32'(rx_pulses), 32'(pulses0));
        rx_q.push_back(10'h155);
        start_frame(10'h155, 10);
        tick();
        chk("abort_next_rx_valid", 32'(bus.rx_valid), 32'd1);
        bus.ss_n = 1'b1;
        tick();
        tick();
        chk("abort_rx_drained", 32'(rx_q.size()), 32'd0);

        // reset in the middle of a response
        bus.tx_data  = 8'h5A;
        bus.tx_valid = 1'b1;
        rx_q.push_back(10'h3A5);
        mb_q.push_back(1'b0);
        mb_q.push_back(1'b1);
        mb_q.push_back(1'b0);
        start_frame(10'h3A5, 10);
        tick();
        tick();
        tick();
        tick();
        chk("mid_tx_bits", 32'(mb_q.size()), 32'd0);
        chk("mid_tx_valid", 32'(bus.valid_MISO), 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst_miso", 32'(bus.MISO), 32'd0);
        chk("mrst_valid_miso", 32'(bus.valid_MISO), 32'd0);
        chk("mrst_sready", 32'(sready), 32'd1);
        chk("mrst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("mrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        rst          = 1'b0;
        bus.tx_valid = 1'b0;
        bus.ss_n     = 1'b1;
        tick();
        tick();

`ifdef SPI_SLV_TIMEOUT_EN
        // read with no response: all-ones after the timeout, sticky err
        rx_q.push_back(10'h300);
        push_byte(8'hFF);
        start_frame(10'h300, 10);
        tick();
        w = 0;
        while (bus.valid_MISO !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk("tmo_wait", 32'(w), 32'd16);
        chk("tmo_err_set", 32'(err), 32'd1);
        for (int i = 0; i < 20 && bus.valid_MISO === 1'b1; i++) tick();
        chk("tmo_bits_drained", 32'(mb_q.size()), 32'd0);
        bus.ss_n = 1'b1;
        tick();
        tick();
        chk("tmo_err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        chk("tmo_err_cleared", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
`else
        w = 0;
        chk("no_tmo_err", 32'(err + w), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
